// File: rtl/param_register_bank.sv
// rtl/param_register_bank.sv - parameter register bank filled by shift-in or addressed writes
// The whole bank is handed off once every entry holds valid data.
module param_register_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   mode,
    input  logic [AW-1:0]          addr,
    input  logic [WIDTH-1:0]       D,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DEPTH*WIDTH-1:0] Q,
    output logic [AW:0]            count
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic             consume;
    logic             accept;
    logic             addr_hit;
    logic [AW:0]      count_c;

    assign out_valid = &valid_q;
    assign in_ready  = !out_valid || out_ready;
    assign consume   = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    assign addr_hit  = {1'b0, addr} < (AW+1)'(DEPTH);

    // Consume clears the valid bits before the write lands, so a same-edge
    // write always starts a fresh fill.
    always_comb begin
        data_d  = data_q;
        valid_d = consume ? '0 : valid_q;
        if (accept) begin
            if (!mode) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    data_d[i] = data_q[i-1];
                end
                data_d[0] = D;
                valid_d   = {valid_d[DEPTH-2:0], 1'b1};
            end else if (addr_hit) begin
                data_d[addr]  = D;
                valid_d[addr] = 1'b1;
            end
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        count_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_c = count_c + (AW+1)'(valid_q[i]);
        end
    end

    assign count = count_c;

    for (genvar g = 0; g < DEPTH; g++) begin : g_q
        assign Q[g*WIDTH +: WIDTH] = data_q[g];
    end

endmodule

// File: tb/tb_param_register_bank.sv
// tb/tb_param_register_bank.sv - scoreboard bench for param_register_bank
module tb_param_register_bank;

    localparam int DP = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  addr = '0;
    logic [7:0]  D = '0;
    logic        in_ready, out_valid;
    logic [31:0] Q;
    logic [2:0]  count;

    logic        clr3 = 1'b0, mode3 = 1'b1, in_valid3 = 1'b0, out_ready3 = 1'b0;
    logic [1:0]  addr3 = '0;
    logic [7:0]  D3 = '0;
    logic        in_ready3, out_valid3;
    logic [23:0] Q3;
    logic [2:0]  count3;

    param_register_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK(CLK), .reset(reset), .clr(clr), .mode(mode), .addr(addr), .D(D),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .Q(Q), .count(count)
    );

    param_register_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
        .CLK(CLK), .reset(reset), .clr(clr3), .mode(mode3), .addr(addr3), .D(D3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_ready(out_ready3),
        .out_valid(out_valid3), .Q(Q3), .count(count3)
    );

    typedef struct {
        int          cyc;
        logic [31:0] q;
        int          cnt;
        bit          ov;
        bit          ir;
    } exp_t;

    exp_t     sb[$];
    int       cyc = 0;
    int       tests = 0;
    int       fails = 0;
    bit [7:0] md[DP];
    bit       mv[DP];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < DP; i++) if (!mv[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DP; i++) n += int'(mv[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_pack();
        logic [31:0] p = '0;
        for (int i = 0; i < DP; i++) p = p | (32'(md[i]) << (8 * i));
        return p;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DP; i++) begin
            md[i] = '0;
            mv[i] = 1'b0;
        end
    endtask

    // One clock of stimulus; the model predicts the bank after the coming edge.
    task automatic step(bit c, bit m, int a, int d, bit iv, bit ordy);
        exp_t e;
        bit   full, acc;
        @(negedge CLK);
        clr = c; mode = m; addr = 2'(a); D = 8'(d); in_valid = iv; out_ready = ordy;
        full = m_full();
        acc  = iv && (!full || ordy);
        if (c) begin
            m_clear();
        end else begin
            if (full && ordy) for (int i = 0; i < DP; i++) mv[i] = 1'b0;
            if (acc && !m) begin
                for (int i = DP - 1; i > 0; i--) begin
                    md[i] = md[i-1];
                    mv[i] = mv[i-1];
                end
                md[0] = 8'(d);
                mv[0] = 1'b1;
            end else if (acc && a < DP) begin
                md[a] = 8'(d);
                mv[a] = 1'b1;
            end
        end
        e.cyc = cyc + 1;
        e.q   = m_pack();
        e.cnt = m_count();
        e.ov  = m_full();
        e.ir  = !e.ov || ordy;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_q", 64'(Q), 64'(e.q));
                chk("sb_count", 64'(count), 64'(e.cnt));
                chk("sb_out_valid", 64'(out_valid), 64'(e.ov));
                chk("sb_in_ready", 64'(in_ready), 64'(e.ir));
            end
        end
    end

    initial begin
        m_clear();
        repeat (2) @(negedge CLK);
        chk("reset_q", 64'(Q), 64'h0);
        chk("reset_count", 64'(count), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        reset = 1'b1;

        // DEPTH=3 bank: address 3 is out of range
        @(negedge CLK);
        in_valid3 = 1'b1; addr3 = 2'd3; D3 = 8'h5A;
        @(posedge CLK); #1;
        chk("d3_oob_count", 64'(count3), 64'h0);
        chk("d3_oob_q", 64'(Q3), 64'h0);
        chk("d3_oob_in_ready", 64'(in_ready3), 64'h1);
        @(negedge CLK);
        addr3 = 2'd2;
        @(posedge CLK); #1;
        chk("d3_a2_count", 64'(count3), 64'h1);
        chk("d3_a2_q", 64'(Q3), 64'h5A0000);
        in_valid3 = 1'b0;

        // shift fill 1..4
        for (int i = 1; i <= 4; i++) step(0, 0, 0, i, 1, 0);
        @(posedge CLK); #2;
        chk("fill_q", 64'(Q), 64'h01020304);
        chk("fill_in_ready", 64'(in_ready), 64'h0);

        // stall three cycles, then consume
        for (int i = 0; i < 3; i++) step(0, 0, 0, 9, 1, 0);
        step(0, 0, 0, 9, 0, 1);
        @(posedge CLK); #2;
        chk("consume_q", 64'(Q), 64'h01020304);
        chk("consume_count", 64'(count), 64'h0);

        // addressed writes with overwrite
        step(0, 1, 2, 8'hAA, 1, 0);
        step(0, 1, 2, 8'h55, 1, 0);
        step(0, 1, 0, 8'h11, 1, 0);
        @(posedge CLK); #2;
        chk("addr_q", 64'(Q), 64'h01550311);
        chk("addr_count", 64'(count), 64'h2);

        // simultaneous consume and addressed write
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h20 + i, 1, 0);
        step(0, 1, 1, 8'h7F, 1, 1);
        @(posedge CLK); #2;
        chk("simul_count", 64'(count), 64'h1);
        chk("simul_entry1", 64'(Q[15:8]), 64'h7F);
        chk("simul_out_valid", 64'(out_valid), 64'h0);

        // shift while full and consumed
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h30 + i, 1, 0);
        step(0, 0, 0, 8'h44, 1, 1);

        // clr priority
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h40 + i, 1, 0);
        step(1, 0, 0, 8'hEE, 1, 1);
        @(posedge CLK); #2;
        chk("clr_q", 64'(Q), 64'h0);
        chk("clr_count", 64'(count), 64'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        // async reset mid-fill
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 8'h01, 1, 0);
        step(0, 1, 3, 8'h02, 1, 0);
        @(posedge CLK); #3;
        in_valid = 1'b0; clr = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_q", 64'(Q), 64'h0);
        chk("async_count", 64'(count), 64'h0);
        chk("async_in_ready", 64'(in_ready), 64'h1);
        m_clear();
        @(negedge CLK);
        reset = 1'b1;
        step(0, 0, 0, 8'h10, 1, 0);
        @(posedge CLK); #2;
        chk("post_reset_count", 64'(count), 64'h1);
        chk("post_reset_entry0", 64'(Q[7:0]), 64'h10);

        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_register_bank.md
PARAM_REGISTER_BANK -- requirements
Module: param_register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per entry (legal range 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of entries (legal range 2..16); AW = max(1, clog2(DEPTH)).
REQ-003 The block SHALL have port CLK  input  1  rising-edge clock; sole clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clr  input  1  synchronous clear, active-high.
REQ-006 The block SHALL have port mode  input  1  write mode: 0 = shift-in, 1 = addressed write.
REQ-007 The block SHALL have port addr  input  AW  target entry in addressed mode.
REQ-008 The block SHALL have port D  input  WIDTH  write data.
REQ-009 The block SHALL have port in_valid  input  1  write request.
REQ-010 The block SHALL have port in_ready  output  1  block can accept a write.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes the full bank.
REQ-012 The block SHALL have port out_valid  output  1  all entries valid (bank full).
REQ-013 The block SHALL have port Q  output  DEPTH*WIDTH  entry i on bits [i*WIDTH +: WIDTH].
REQ-014 The block SHALL have port count  output  AW+1  number of valid entries.

Function
REQ-015 Storage: DEPTH data registers of WIDTH bits plus one valid bit per entry; Q is the registers, driven directly (no extra latency).
REQ-016 Write accept: in_valid && in_ready at a rising CLK edge; the write takes effect on that edge.
REQ-017 Shift mode (mode=0) accept: entry[0] <= D, entry[i] <= entry[i-1] for i=1..DEPTH-1, valid bits shift likewise with valid[0] <= 1; entry[DEPTH-1] is discarded.
REQ-018 Addressed mode (mode=1) accept: entry[addr] <= D, valid[addr] <= 1; other entries unchanged.
REQ-019 Addressed mode with addr >= DEPTH: handshake completes, storage and valid bits unchanged.
REQ-020 Rewriting an already-valid entry in addressed mode overwrites data; count unchanged.
REQ-021 out_valid SHALL equal AND of all valid bits (combinational from registers).
REQ-022 count SHALL equal population count of valid bits, range 0..DEPTH.
REQ-023 Consume: out_valid && out_ready at an edge clears all valid bits; data registers retain values.
REQ-024 in_ready SHALL equal (!out_valid) || out_ready; writes are stalled while the bank is full and not being consumed.
REQ-025 Simultaneous consume and write, same edge: valid bits cleared first, then the write applied, so afterwards count = 1 (0 if addr out of range) and only the written entry is valid.
REQ-026 Shift mode when full and consumed in the same edge: the shift applies to the data; the valid result is per REQ-025.
REQ-027 clr=1 at an edge: all data registers to 0, all valid bits to 0; clr overrides any write or consume on that edge; in_ready is unaffected by clr.
REQ-028 mode, addr and D are sampled only on an accepted write; their values are don't-care otherwise.
REQ-029 No output SHALL depend combinationally on D, mode or addr.

Reset
REQ-030 reset=0 SHALL immediately, independent of CLK, force all data registers to 0, all valid bits to 0, count=0, out_valid=0, in_ready=1.
REQ-031 Reset asserted mid-fill SHALL discard the partial fill; the first accepted write after release starts from count=0.
REQ-032 Release of reset SHALL be treated as synchronous to CLK by the integrating logic; the block has no internal synchronizer.

Verification (WIDTH=8, DEPTH=4)
REQ-033 Shift fill: from reset, shift-write 1,2,3,4 on consecutive edges -> Q = {1,2,3,4} (entry3..entry0), count steps 1,2,3,4; out_valid=1 after the 4th edge and in_ready=0 with out_ready=0.
REQ-034 Stall: bank full, out_ready=0, in_valid=1 with D=9 for 3 cycles -> Q unchanged, count=4; then out_ready=1 for one edge -> count=0, out_valid=0, Q still {1,2,3,4}.
REQ-035 Addressed write: write addr=2 D=0xAA, then addr=2 D=0x55, then addr=0 D=0x11 -> entry2=0x55, entry0=0x11, count=2; addr=5 is not reachable (AW=2); for DEPTH=3, addr=3 write -> no change, in_ready stays 1.
REQ-036 Simultaneous: full bank, out_ready=1 and addressed write addr=1 D=0x7F on the same edge -> count=1, valid only entry1, entry1=0x7F, out_valid=0.
REQ-037 clr priority: full bank, clr=1 with in_valid=1 and out_ready=1 -> all Q=0, count=0 next cycle.
REQ-038 Async reset: count=2, assert reset=0 between clock edges -> Q=0 and count=0 before the next CLK edge; release, shift-write 0x10 -> count=1, entry0=0x10.
